// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, status bit positions and op legality helper
package alu_pkg;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam int ST_ZERO = 2;
    localparam int ST_NEG  = 1;
    localparam int ST_OVF  = 0;
    localparam logic [2:0] ILLEGAL_STATUS = 3'(1 << ST_ZERO);
    function automatic logic is_legal_op(input logic [2:0] op);
        return op != 3'b011 && op != 3'b100;
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; last remembers the most recently granted port
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] eligible,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       last
);
    always_comb begin
        grant[0] = eligible[0] && (!eligible[1] || last);
        grant[1] = eligible[1] && (!eligible[0] || !last);
    end

    always_ff @(posedge clk) begin
        if (reset)
            last <= 1'b1;
        else if (accept)
            last <= grant[1];
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU between two
// requesters, with a registered operand stage and a one-entry response slot per port
module alu_arbiter
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_b_1,
    input  logic [2:0]  req_op_0,
    input  logic [2:0]  req_op_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [31:0] rsp_sum_0,
    output logic [31:0] rsp_sum_1,
    output logic [2:0]  rsp_status_0,
    output logic [2:0]  rsp_status_1,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_gin,
    input  logic [31:0] alu_sum,
    input  logic [2:0]  alu_status
);
    logic        s1_valid;
    logic        s1_tag;
    logic        last;
    logic [1:0]  eligible;
    logic [1:0]  grant;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_sum [2];
    logic [2:0]  rsp_status [2];
    logic        legal;

    // ready must stay low while reset is held, so eligibility is masked by it
    always_comb begin
        eligible[0] = !reset && req_valid_0 && !rsp_valid[0] && !(s1_valid && !s1_tag);
        eligible[1] = !reset && req_valid_1 && !rsp_valid[1] && !(s1_valid && s1_tag);
        rsp_ready   = {rsp_ready_1, rsp_ready_0};
        legal       = is_legal_op(alu_gin);
    end

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .eligible (eligible),
        .accept   (|grant),
        .grant    (grant),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_tag   <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_gin  <= ALU_ADD;
        end else begin
            s1_valid <= |grant;
            if (|grant) begin
                s1_tag  <= grant[1];
                alu_a   <= grant[1] ? req_a_1 : req_a_0;
                alu_b   <= grant[1] ? req_b_1 : req_b_0;
                alu_gin <= grant[1] ? req_op_1 : req_op_0;
            end
        end
    end

    // a slot is never full when its port's op sits in S1, so capture and drain cannot collide
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= '0;
            for (int i = 0; i < 2; i++) begin
                rsp_sum[i]    <= '0;
                rsp_status[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s1_valid && s1_tag == i[0]) begin
                    rsp_valid[i]  <= 1'b1;
                    rsp_sum[i]    <= legal ? alu_sum : '0;
                    rsp_status[i] <= legal ? alu_status : ILLEGAL_STATUS;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        req_ready_0  = grant[0];
        req_ready_1  = grant[1];
        rsp_valid_0  = rsp_valid[0];
        rsp_valid_1  = rsp_valid[1];
        rsp_sum_0    = rsp_sum[0];
        rsp_sum_1    = rsp_sum[1];
        rsp_status_0 = rsp_status[0];
        rsp_status_1 = rsp_status[1];
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter against hand-computed results,
// with a behavioural model standing in for the external ALU
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_a_0 = '0, req_a_1 = '0, req_b_0 = '0, req_b_1 = '0;
    logic [2:0]  req_op_0 = '0, req_op_1 = '0;
    logic        rsp_valid_0, rsp_valid_1;
    logic        rsp_ready_0 = 1'b1, rsp_ready_1 = 1'b1;
    logic [31:0] rsp_sum_0, rsp_sum_1;
    logic [2:0]  rsp_status_0, rsp_status_1;
    logic [31:0] alu_a, alu_b, alu_sum;
    logic [2:0]  alu_gin, alu_status;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_sum_0(rsp_sum_0), .rsp_sum_1(rsp_sum_1),
        .rsp_status_0(rsp_status_0), .rsp_status_1(rsp_status_1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_gin(alu_gin),
        .alu_sum(alu_sum), .alu_status(alu_status)
    );

    // external ALU model; undefined codes give a^b so forcing is visible
    logic ovf;
    always_comb begin
        ovf = 1'b0;
        case (alu_gin)
            3'b000: alu_sum = alu_a & alu_b;
            3'b001: alu_sum = alu_a | alu_b;
            3'b010: begin
                alu_sum = alu_a + alu_b;
                ovf = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
            end
            3'b101: alu_sum = alu_a << alu_b[4:0];
            3'b110: begin
                alu_sum = alu_a - alu_b;
                ovf = (alu_a[31] != alu_b[31]) && (alu_sum[31] != alu_a[31]);
            end
            3'b111: alu_sum = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_sum = alu_a ^ alu_b;
        endcase
        alu_status = {alu_sum == 32'b0, alu_sum[31], ovf};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit p, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        if (p) begin
            req_valid_1 = v; req_a_1 = a; req_b_1 = b; req_op_1 = op;
        end else begin
            req_valid_0 = v; req_a_0 = a; req_b_0 = b; req_op_0 = op;
        end
    endtask

    function automatic logic rdy(input bit p);
        return p ? req_ready_1 : req_ready_0;
    endfunction
    function automatic logic rv(input bit p);
        return p ? rsp_valid_1 : rsp_valid_0;
    endfunction
    function automatic logic [31:0] rs(input bit p);
        return p ? rsp_sum_1 : rsp_sum_0;
    endfunction
    function automatic logic [2:0] rst_of(input bit p);
        return p ? rsp_status_1 : rsp_status_0;
    endfunction

    // single-port op: handshake in c, operands on the ALU in c+1, response in c+2
    task automatic do_op(input string tag, input bit p, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] es, input logic [2:0] est);
        tick();
        set_req(p, 1'b1, a, b, op);
        #1 chk({tag, "_ready"}, 32'(rdy(p)), 32'd1);
        tick();
        set_req(p, 1'b0, '0, '0, '0);
        #1 chk({tag, "_alu_a"}, alu_a, a);
        chk({tag, "_alu_gin"}, 32'(alu_gin), 32'(op));
        chk({tag, "_rsp_early"}, 32'(rv(p)), 32'd0);
        tick();
        #1 chk({tag, "_rsp_valid"}, 32'(rv(p)), 32'd1);
        chk({tag, "_sum"}, rs(p), es);
        chk({tag, "_status"}, 32'(rst_of(p)), 32'(est));
        tick();
        #1 chk({tag, "_drained"}, 32'(rv(p)), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rdy0"}, 32'(req_ready_0), 32'd0);
        chk({tag, "_rdy1"}, 32'(req_ready_1), 32'd0);
        chk({tag, "_rv"}, {30'b0, rsp_valid_1, rsp_valid_0}, 32'd0);
        chk({tag, "_sums"}, rsp_sum_0 | rsp_sum_1, 32'd0);
        chk({tag, "_stats"}, 32'(rsp_status_0 | rsp_status_1), 32'd0);
        chk({tag, "_alu_ab"}, alu_a | alu_b, 32'd0);
        chk({tag, "_alu_gin"}, 32'(alu_gin), 32'd2);
    endtask

    initial begin
        tick();
        tick();
        #1 check_reset_state("reset");
        reset = 1'b0;

        do_op("add", 1'b0, 32'd5, 32'd7, 3'b010, 32'd12, 3'b000);
        do_op("sub", 1'b1, 32'd3, 32'd3, 3'b110, 32'd0, 3'b100);

        // tie straight after reset: port 0 first, then port 1
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(1'b0, 1'b1, 32'h0000_00F0, 32'h0000_000F, 3'b001);
        set_req(1'b1, 1'b1, 32'd1, 32'd4, 3'b101);
        #1 chk("tie_rdy0", 32'(req_ready_0), 32'd1);
        chk("tie_rdy1", 32'(req_ready_1), 32'd0);
        tick();
        set_req(1'b0, 1'b0, '0, '0, '0);
        #1 chk("tie_rdy1_next", 32'(req_ready_1), 32'd1);
        chk("tie_gin_or", 32'(alu_gin), 32'd1);
        tick();
        set_req(1'b1, 1'b0, '0, '0, '0);
        #1 chk("tie_rsp0", 32'(rsp_valid_0), 32'd1);
        chk("tie_sum0", rsp_sum_0, 32'h0000_00FF);
        chk("tie_gin_sll", 32'(alu_gin), 32'd5);
        tick();
        #1 chk("tie_rsp1", 32'(rsp_valid_1), 32'd1);
        chk("tie_sum1", rsp_sum_1, 32'd16);
        chk("tie_st1", 32'(rsp_status_1), 32'd0);

        // full port-0 slot blocks port 0 while port 1 keeps going
        tick();
        rsp_ready_0 = 1'b0;
        set_req(1'b0, 1'b1, 32'd1, 32'd1, 3'b010);
        tick();
        set_req(1'b0, 1'b0, '0, '0, '0);
        tick();
        set_req(1'b0, 1'b1, 32'd2, 32'd2, 3'b010);
        set_req(1'b1, 1'b1, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'b000);
        #1 chk("hold_rsp0", 32'(rsp_valid_0), 32'd1);
        chk("hold_sum0", rsp_sum_0, 32'd2);
        chk("hold_rdy0_a", 32'(req_ready_0), 32'd0);
        chk("hold_rdy1_a", 32'(req_ready_1), 32'd1);
        tick();
        #1 chk("hold_rdy0_b", 32'(req_ready_0), 32'd0);
        chk("hold_rdy1_b", 32'(req_ready_1), 32'd0);
        tick();
        rsp_ready_0 = 1'b1;
        set_req(1'b1, 1'b0, '0, '0, '0);
        #1 chk("hold_rdy0_c", 32'(req_ready_0), 32'd0);
        chk("hold_rsp1", 32'(rsp_valid_1), 32'd1);
        chk("hold_sum1", rsp_sum_1, 32'h0F00_0F00);
        tick();
        #1 chk("drain_rsp0", 32'(rsp_valid_0), 32'd0);
        chk("drain_rdy0", 32'(req_ready_0), 32'd1);
        tick();
        set_req(1'b0, 1'b0, '0, '0, '0);
        tick();
        #1 chk("after_rsp0", 32'(rsp_valid_0), 32'd1);
        chk("after_sum0", rsp_sum_0, 32'd4);

        do_op("slt", 1'b0, 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1, 3'b000);
        do_op("ill3", 1'b0, 32'd5, 32'd6, 3'b011, 32'd0, 3'b100);
        do_op("ill4", 1'b1, 32'h8000_0000, 32'd9, 3'b100, 32'd0, 3'b100);
        do_op("ovf", 1'b1, 32'h7FFF_FFFF, 32'd1, 3'b010, 32'h8000_0000, 3'b011);

        // reset while S1 holds an op discards it
        tick();
        set_req(1'b0, 1'b1, 32'd10, 32'd20, 3'b010);
        tick();
        set_req(1'b0, 1'b0, '0, '0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1 check_reset_state("midrst_a");
        tick();
        #1 check_reset_state("midrst_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
